// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave port between NUM_MST masters.
// One transaction (read or write) is in flight at a time. The response is
// routed back to the granted master only. Arbitration restarts after that.
module axi_lite_rr_arbiter #(
  parameter int NUM_MST    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  // master side, master i at slice i
  input  logic [NUM_MST*ADDR_WIDTH-1:0]       mst_aw_addr_i,
  input  logic [NUM_MST-1:0]                  mst_aw_valid_i,
  output logic [NUM_MST-1:0]                  mst_aw_ready_o,
  input  logic [NUM_MST*DATA_WIDTH-1:0]       mst_w_data_i,
  input  logic [NUM_MST*(DATA_WIDTH/8)-1:0]   mst_w_strb_i,
  input  logic [NUM_MST-1:0]                  mst_w_valid_i,
  output logic [NUM_MST-1:0]                  mst_w_ready_o,
  output logic [1:0]                          mst_b_resp_o,
  output logic [NUM_MST-1:0]                  mst_b_valid_o,
  input  logic [NUM_MST-1:0]                  mst_b_ready_i,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]       mst_ar_addr_i,
  input  logic [NUM_MST-1:0]                  mst_ar_valid_i,
  output logic [NUM_MST-1:0]                  mst_ar_ready_o,
  output logic [DATA_WIDTH-1:0]               mst_r_data_o,
  output logic [1:0]                          mst_r_resp_o,
  output logic [NUM_MST-1:0]                  mst_r_valid_o,
  input  logic [NUM_MST-1:0]                  mst_r_ready_i,
  // slave side
  output logic [ADDR_WIDTH-1:0]               slv_aw_addr_o,
  output logic                                slv_aw_valid_o,
  input  logic                                slv_aw_ready_i,
  output logic [DATA_WIDTH-1:0]               slv_w_data_o,
  output logic [DATA_WIDTH/8-1:0]             slv_w_strb_o,
  output logic                                slv_w_valid_o,
  input  logic                                slv_w_ready_i,
  input  logic [1:0]                          slv_b_resp_i,
  input  logic                                slv_b_valid_i,
  output logic                                slv_b_ready_o,
  output logic [ADDR_WIDTH-1:0]               slv_ar_addr_o,
  output logic                                slv_ar_valid_o,
  input  logic                                slv_ar_ready_i,
  input  logic [DATA_WIDTH-1:0]               slv_r_data_i,
  input  logic [1:0]                          slv_r_resp_i,
  input  logic                                slv_r_valid_i,
  output logic                                slv_r_ready_o,
  // status
  output logic                                busy_o,
  output logic [$clog2(NUM_MST)-1:0]          grant_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int GW     = $clog2(NUM_MST);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_e;

  state_e               state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        rr_ptr;
  logic                 last_wr;
  logic                 aw_done;
  logic                 w_done;

  logic [NUM_MST-1:0]   rd_req;
  logic [NUM_MST-1:0]   wr_req;
  logic [NUM_MST-1:0]   req;
  logic                 found;
  logic [GW-1:0]        win;
  logic [GW-1:0]        rr_nxt;
  logic                 aw_hs;
  logic                 w_hs;

  // A write only counts as a request once both AW and W are presented, so a
  // lone AW never stalls the other masters.
  assign rd_req = mst_ar_valid_i;
  assign wr_req = mst_aw_valid_i & mst_w_valid_i;
  assign req    = rd_req | wr_req;

  // Scan requests starting at rr_ptr, wrapping modulo NUM_MST.
  always_comb begin
    int c;
    found = 1'b0;
    win   = '0;
    c     = 0;
    for (int k = 0; k < NUM_MST; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NUM_MST) c = c - NUM_MST;
      if (!found && req[c[GW-1:0]]) begin
        found = 1'b1;
        win   = c[GW-1:0];
      end
    end
    rr_nxt = (int'(win) == NUM_MST - 1) ? '0 : win + 1'b1;
  end

  assign aw_hs = (state == AW_W) && !aw_done && slv_aw_ready_i;
  assign w_hs  = (state == AW_W) && !w_done  && slv_w_ready_i;

  // Channel routing: valids/readies follow the registered state and grant only,
  // so no master valid reaches a slave valid combinationally.
  always_comb begin
    mst_aw_ready_o = '0;
    mst_w_ready_o  = '0;
    mst_b_valid_o  = '0;
    mst_ar_ready_o = '0;
    mst_r_valid_o  = '0;
    slv_aw_valid_o = 1'b0;
    slv_w_valid_o  = 1'b0;
    slv_b_ready_o  = 1'b0;
    slv_ar_valid_o = 1'b0;
    slv_r_ready_o  = 1'b0;
    case (state)
      AR: begin
        slv_ar_valid_o        = 1'b1;
        mst_ar_ready_o[grant] = slv_ar_ready_i;
      end
      R: begin
        mst_r_valid_o[grant] = slv_r_valid_i;
        slv_r_ready_o        = mst_r_ready_i[grant];
      end
      AW_W: begin
        slv_aw_valid_o        = !aw_done;
        slv_w_valid_o         = !w_done;
        mst_aw_ready_o[grant] = slv_aw_ready_i && !aw_done;
        mst_w_ready_o[grant]  = slv_w_ready_i && !w_done;
      end
      B: begin
        mst_b_valid_o[grant] = slv_b_valid_i;
        slv_b_ready_o        = mst_b_ready_i[grant];
      end
      default: ;
    endcase
  end

  // Payload muxes from the granted master; response payloads are broadcast.
  assign slv_aw_addr_o = mst_aw_addr_i[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign slv_ar_addr_o = mst_ar_addr_i[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign slv_w_data_o  = mst_w_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
  assign slv_w_strb_o  = mst_w_strb_i[grant*STRB_W +: STRB_W];
  assign mst_r_data_o  = slv_r_data_i;
  assign mst_r_resp_o  = slv_r_resp_i;
  assign mst_b_resp_o  = slv_b_resp_i;

  assign busy_o  = (state != IDLE);
  assign grant_o = grant;

  // Transaction FSM: grant in IDLE, then walk the address/data/response phases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      last_wr <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= win;
            rr_ptr <= rr_nxt;
            // With both kinds pending, alternate relative to the last choice.
            if (wr_req[win] && (!rd_req[win] || !last_wr)) begin
              state   <= AW_W;
              last_wr <= 1'b1;
            end else begin
              state   <= AR;
              last_wr <= 1'b0;
            end
          end
        end
        AR: begin
          if (slv_ar_ready_i) state <= R;
        end
        R: begin
          if (slv_r_valid_i && mst_r_ready_i[grant]) state <= IDLE;
        end
        AW_W: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= B;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        B: begin
          if (slv_b_valid_i && mst_b_ready_i[grant]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Scoreboard bench for axi_lite_rr_arbiter: directed master transactions,
// a behavioural slave, and a monitor that checks every response delivered.
module tb_axi_lite_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam logic [63:0] RD_OFS = 64'hDEADAEEF;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic [NM*AW-1:0] m_aw_addr = '0;
  logic [NM-1:0]    m_aw_valid = '0;
  logic [NM-1:0]    m_aw_ready;
  logic [NM*DW-1:0] m_w_data = '0;
  logic [NM*SW-1:0] m_w_strb = '0;
  logic [NM-1:0]    m_w_valid = '0;
  logic [NM-1:0]    m_w_ready;
  logic [1:0]       m_b_resp;
  logic [NM-1:0]    m_b_valid;
  logic [NM-1:0]    m_b_ready = '1;
  logic [NM*AW-1:0] m_ar_addr = '0;
  logic [NM-1:0]    m_ar_valid = '0;
  logic [NM-1:0]    m_ar_ready;
  logic [DW-1:0]    m_r_data;
  logic [1:0]       m_r_resp;
  logic [NM-1:0]    m_r_valid;
  logic [NM-1:0]    m_r_ready = '1;

  logic [AW-1:0] s_aw_addr;
  logic          s_aw_valid;
  logic          s_aw_ready = 1'b0;
  logic [DW-1:0] s_w_data;
  logic [SW-1:0] s_w_strb;
  logic          s_w_valid;
  logic          s_w_ready = 1'b0;
  logic [1:0]    s_b_resp = 2'b00;
  logic          s_b_valid = 1'b0;
  logic          s_b_ready;
  logic [AW-1:0] s_ar_addr;
  logic          s_ar_valid;
  logic          s_ar_ready = 1'b1;
  logic [DW-1:0] s_r_data = '0;
  logic [1:0]    s_r_resp = 2'b00;
  logic          s_r_valid = 1'b0;
  logic          s_r_ready;

  logic          busy;
  logic [1:0]    grant;

  axi_lite_rr_arbiter #(.NUM_MST(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mst_aw_addr_i(m_aw_addr), .mst_aw_valid_i(m_aw_valid), .mst_aw_ready_o(m_aw_ready),
    .mst_w_data_i(m_w_data), .mst_w_strb_i(m_w_strb), .mst_w_valid_i(m_w_valid),
    .mst_w_ready_o(m_w_ready),
    .mst_b_resp_o(m_b_resp), .mst_b_valid_o(m_b_valid), .mst_b_ready_i(m_b_ready),
    .mst_ar_addr_i(m_ar_addr), .mst_ar_valid_i(m_ar_valid), .mst_ar_ready_o(m_ar_ready),
    .mst_r_data_o(m_r_data), .mst_r_resp_o(m_r_resp), .mst_r_valid_o(m_r_valid),
    .mst_r_ready_i(m_r_ready),
    .slv_aw_addr_o(s_aw_addr), .slv_aw_valid_o(s_aw_valid), .slv_aw_ready_i(s_aw_ready),
    .slv_w_data_o(s_w_data), .slv_w_strb_o(s_w_strb), .slv_w_valid_o(s_w_valid),
    .slv_w_ready_i(s_w_ready),
    .slv_b_resp_i(s_b_resp), .slv_b_valid_i(s_b_valid), .slv_b_ready_o(s_b_ready),
    .slv_ar_addr_o(s_ar_addr), .slv_ar_valid_o(s_ar_valid), .slv_ar_ready_i(s_ar_ready),
    .slv_r_data_i(s_r_data), .slv_r_resp_i(s_r_resp), .slv_r_valid_i(s_r_valid),
    .slv_r_ready_o(s_r_ready),
    .busy_o(busy), .grant_o(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: kind 0 = read response, 1 = write response.
  typedef struct {
    bit          kind;
    int          mst;
    logic [63:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  task automatic push(input bit kind, input int m, input logic [63:0] d, input logic [1:0] r);
    exp_t e;
    e.kind = kind; e.mst = m; e.data = d; e.resp = r;
    sb.push_back(e);
  endtask

  // Behavioural slave configuration and observations.
  int          aw_delay = 0, w_delay = 0;
  bit          r_stall = 0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [63:0] cap_aw_addr = '0, cap_w_data = '0;
  logic [7:0]  cap_w_strb = '0;

  // Slave model: AR always ready, R one cycle after AR, AW/W ready after a
  // programmable wait, B once both write channels have completed.
  initial begin
    int scyc = 0, aw_cnt = 0, w_cnt = 0;
    bit rd_pend = 0, aw_got = 0, w_got = 0;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [63:0] rd_addr = '0;
    forever begin
      @(negedge clk);
      scyc++;
      ar_hs = rst_ni && s_ar_valid && s_ar_ready;
      r_hs  = rst_ni && s_r_valid && s_r_ready;
      aw_hs = rst_ni && s_aw_valid && s_aw_ready;
      w_hs  = rst_ni && s_w_valid && s_w_ready;
      b_hs  = rst_ni && s_b_valid && s_b_ready;
      aw_cnt = s_aw_valid ? aw_cnt + 1 : 0;
      w_cnt  = s_w_valid ? w_cnt + 1 : 0;
      if (ar_hs) rd_addr = s_ar_addr;
      if (aw_hs) begin cap_aw_addr = s_aw_addr; aw_hs_n++; aw_hs_cyc = scyc; end
      if (w_hs) begin cap_w_data = s_w_data; cap_w_strb = s_w_strb; w_hs_n++; w_hs_cyc = scyc; end
      if (b_hs) b_hs_n++;
      @(posedge clk);
      #1;
      if (!rst_ni) begin
        rd_pend = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        s_r_valid = 0; s_b_valid = 0; s_aw_ready = 0; s_w_ready = 0;
      end else begin
        if (r_hs) s_r_valid = 0;
        if (ar_hs) rd_pend = 1;
        if (rd_pend && !r_stall && !s_r_valid) begin
          s_r_valid = 1; s_r_data = rd_addr + RD_OFS; s_r_resp = cfg_rresp; rd_pend = 0;
        end
        s_aw_ready = (aw_cnt > aw_delay);
        s_w_ready  = (w_cnt > w_delay);
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (b_hs) s_b_valid = 0;
        if (aw_got && w_got && !s_b_valid) begin
          s_b_valid = 1; s_b_resp = cfg_bresp; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  // Monitor: every response delivered to a master is popped and compared.
  bit gap_chk = 0;
  int last_r_cyc = -1;
  initial begin
    int cyc = 0;
    exp_t e;
    logic [NM-1:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_ni) begin
        for (int i = 0; i < NM; i++) begin
          oh = '0; oh[i] = 1'b1;
          if (m_r_valid[i] && m_r_ready[i]) begin
            chk("r_valid_onehot", m_r_valid, oh);
            if (sb.size() == 0) chk("r_unexpected", 1, 0);
            else begin
              e = sb.pop_front();
              chk("r_kind", 0, e.kind);
              chk("r_master", i, e.mst);
              chk("r_data", m_r_data, e.data);
              chk("r_resp", m_r_resp, e.resp);
            end
            if (gap_chk && last_r_cyc >= 0) chk("r_gap_ge3", (cyc - last_r_cyc) >= 3, 1);
            last_r_cyc = cyc;
          end
          if (m_b_valid[i] && m_b_ready[i]) begin
            chk("b_valid_onehot", m_b_valid, oh);
            if (sb.size() == 0) chk("b_unexpected", 1, 0);
            else begin
              e = sb.pop_front();
              chk("b_kind", 1, e.kind);
              chk("b_master", i, e.mst);
              chk("b_resp", m_b_resp, e.resp);
            end
          end
        end
      end
    end
  end

  task automatic mrd(input int m, input logic [63:0] addr);
    bit hs = 0;
    logic [NM-1:0] oh = '0;
    oh[m] = 1'b1;
    m_ar_addr[m*AW +: AW] = addr;
    m_ar_valid[m] = 1'b1;
    for (int c = 0; c < 300 && !hs; c++) begin
      @(negedge clk);
      if (m_ar_ready[m]) begin
        hs = 1;
        chk("ar_ready_onehot", m_ar_ready, oh);
      end
      @(posedge clk);
      #1;
    end
    m_ar_valid[m] = 1'b0;
    chk("ar_handshake", hs, 1);
  endtask

  task automatic mwr(input int m, input logic [63:0] addr, input logic [63:0] data,
                     input logic [7:0] strb);
    bit ad = 0, wd = 0, a_now, w_now;
    logic [NM-1:0] oh = '0;
    oh[m] = 1'b1;
    m_aw_addr[m*AW +: AW] = addr;
    m_w_data[m*DW +: DW] = data;
    m_w_strb[m*SW +: SW] = strb;
    m_aw_valid[m] = 1'b1;
    m_w_valid[m] = 1'b1;
    for (int c = 0; c < 300 && !(ad && wd); c++) begin
      @(negedge clk);
      a_now = m_aw_valid[m] && m_aw_ready[m];
      w_now = m_w_valid[m] && m_w_ready[m];
      if (a_now) chk("aw_ready_onehot", m_aw_ready, oh);
      if (w_now) chk("w_ready_onehot", m_w_ready, oh);
      @(posedge clk);
      #1;
      if (a_now) begin ad = 1; m_aw_valid[m] = 1'b0; end
      if (w_now) begin wd = 1; m_w_valid[m] = 1'b0; end
    end
    chk("aw_handshake", ad, 1);
    chk("w_handshake", wd, 1);
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    m_aw_valid = '0; m_w_valid = '0; m_ar_valid = '0;
    aw_delay = 0; w_delay = 0; r_stall = 0; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_slv_valids", {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}, 0);
    chk("rst_mst_readies", {m_ar_ready, m_aw_ready, m_w_ready}, 0);
    chk("rst_mst_valids", {m_r_valid, m_b_valid}, 0);
    @(posedge clk);
    #1;

    // Single read from master 2; grant takes effect one cycle later
    push(0, 2, 64'hDEADBEEF, 2'b00);
    m_ar_addr[2*AW +: AW] = 64'h1000;
    m_ar_valid[2] = 1'b1;
    @(negedge clk);
    chk("ar_valid_same_cycle", s_ar_valid, 0);
    @(negedge clk);
    chk("ar_valid_next_cycle", s_ar_valid, 1);
    chk("ar_addr_m2", s_ar_addr, 64'h1000);
    chk("grant_m2", grant, 2);
    chk("ar_ready_only_m2", m_ar_ready, 4'b0100);
    @(posedge clk);
    #1;
    m_ar_valid[2] = 1'b0;
    drain();
    chk("rr_ptr_after_m2", dut.rr_ptr, 3);

    // All four masters read continuously: grants 0,1,2,3,0
    do_reset();
    gap_chk = 1; last_r_cyc = -1;
    push(0, 0, 64'hDEADAFEF, 2'b00);
    push(0, 1, 64'hDEADB0EF, 2'b00);
    push(0, 2, 64'hDEADB1EF, 2'b00);
    push(0, 3, 64'hDEADB2EF, 2'b00);
    push(0, 0, 64'hDEADB3EF, 2'b00);
    fork
      begin mrd(0, 64'h100); mrd(0, 64'h500); end
      mrd(1, 64'h200);
      mrd(2, 64'h300);
      mrd(3, 64'h400);
    join
    drain();
    gap_chk = 0;

    // Master 1 with read and write pending: write, read, write, read
    do_reset();
    push(1, 1, 64'h0, 2'b00);
    push(0, 1, 64'hDEADAF6F, 2'b00);
    fork
      mwr(1, 64'h40, 64'h1111, 8'hFF);
      mrd(1, 64'h80);
    join
    drain();
    push(1, 1, 64'h0, 2'b00);
    push(0, 1, 64'hDEADAF73, 2'b00);
    fork
      mwr(1, 64'h44, 64'h2222, 8'hFF);
      mrd(1, 64'h84);
    join
    drain();

    // Write from master 0: slave takes W two cycles before AW, SLVERR back
    aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0;
    aw_delay = 2; w_delay = 0; cfg_bresp = 2'b10;
    push(1, 0, 64'h0, 2'b10);
    mwr(0, 64'h3000, 64'hCAFEF00D, 8'h0F);
    drain();
    chk("w_first_aw_hs_n", aw_hs_n, 1);
    chk("w_first_w_hs_n", w_hs_n, 1);
    chk("w_first_b_hs_n", b_hs_n, 1);
    chk("w_first_gap", aw_hs_cyc - w_hs_cyc, 2);
    chk("w_first_addr", cap_aw_addr, 64'h3000);
    chk("w_first_data", cap_w_data, 64'hCAFEF00D);
    chk("w_first_strb", cap_w_strb, 8'h0F);

    // Same write path with AW and W accepted in the same cycle
    aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0;
    aw_delay = 0; w_delay = 0;
    push(1, 0, 64'h0, 2'b10);
    mwr(0, 64'h3008, 64'h12345678, 8'hF0);
    drain();
    chk("same_aw_hs_n", aw_hs_n, 1);
    chk("same_w_hs_n", w_hs_n, 1);
    chk("same_b_hs_n", b_hs_n, 1);
    chk("same_gap", aw_hs_cyc - w_hs_cyc, 0);
    chk("same_data", cap_w_data, 64'h12345678);
    chk("same_strb", cap_w_strb, 8'hF0);
    cfg_bresp = 2'b00;

    // Reset asserted while a read from master 1 waits in R
    do_reset();
    r_stall = 1;
    mrd(1, 64'h700);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_r_ready", s_r_ready, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_grant", grant, 0);
    chk("async_slv", {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}, 0);
    chk("async_mst", {m_ar_ready, m_aw_ready, m_w_ready, m_r_valid, m_b_valid}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    r_stall = 0;
    push(0, 0, 64'hDEADAEFF, 2'b00);
    push(0, 3, 64'hDEADAF1F, 2'b00);
    fork
      mrd(0, 64'h10);
      mrd(3, 64'h30);
    join
    drain();

    // AW without W from master 0 must not be granted while master 1 reads
    cfg_rresp = 2'b11;
    m_aw_addr[0 +: AW] = 64'h60;
    m_aw_valid[0] = 1'b1;
    push(0, 1, 64'hDEADB0EF, 2'b11);
    mrd(1, 64'h200);
    drain();
    repeat (3) @(negedge clk);
    chk("aw_only_busy", busy, 0);
    chk("aw_only_no_ready", m_aw_ready, 0);
    chk("aw_only_no_slv", s_aw_valid, 0);
    @(posedge clk);
    #1;
    cfg_rresp = 2'b00;
    push(1, 0, 64'h0, 2'b00);
    mwr(0, 64'h60, 64'hABCD, 8'h03);
    drain();
    chk("aw_only_addr", cap_aw_addr, 64'h60);
    chk("aw_only_data", cap_w_data, 64'hABCD);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
